// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and parity helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_BIT_IDX_W    = $clog2(UART_DATA_W);
    localparam int unsigned UART_FREQ_DEFAULT = 347;
    localparam int unsigned UART_STOP_BITS    = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    // Even parity bit for one data word.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/read_uart.sv
// UART receiver: start, 8 data bits LSB first, optional even parity, 1 stop.
// Bit period is freq+1 clk cycles; freq must be at least 3.
// Optional feature: define READ_UART_PARITY_EN to add the parity bit.
module read_uart
    import uart_pkg::*;
#(
    parameter int unsigned freq = UART_FREQ_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RxD,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    input  logic                   ack,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int unsigned CNT_W = $clog2(freq + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(freq);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(freq / 2);
    localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_W - 1);

    uart_rx_state_t state, state_d;

    logic                      rxs;
    logic                      rxs_q;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [UART_BIT_IDX_W-1:0] bit_idx;
    logic [UART_DATA_W-1:0]    shift_r;
    logic                      stop_bad;
    logic                      load_pend;
    logic                      wait_high;
`ifdef READ_UART_PARITY_EN
    logic                      par_bad;
    logic                      par_c;
`endif
    logic                      shift_c;
    logic                      stop_c;
    logic                      load_c;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (RxD),
        .q   (rxs)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, bit-period counter and per-state sample strobes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shift_c = 1'b0;
        stop_c  = 1'b0;
        load_c  = 1'b0;
`ifdef READ_UART_PARITY_EN
        par_c   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (rxs_q && !rxs && !wait_high) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    cnt_d   = '0;
                    shift_c = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef READ_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
`ifdef READ_UART_PARITY_EN
            PARITY: begin
                if (cnt == CNT_MAX) begin
                    cnt_d   = '0;
                    par_c   = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (load_pend) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt == CNT_MAX) begin
                    cnt_d  = '0;
                    stop_c = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Counters, shift register and frame status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxs_q     <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_r   <= '0;
            stop_bad  <= 1'b0;
            load_pend <= 1'b0;
            wait_high <= 1'b0;
`ifdef READ_UART_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            rxs_q <= rxs;
            cnt   <= cnt_d;
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (shift_c) begin
                bit_idx <= bit_idx + UART_BIT_IDX_W'(1);
                shift_r <= {rxs, shift_r[UART_DATA_W-1:1]};
            end
`ifdef READ_UART_PARITY_EN
            if (par_c) begin
                par_bad <= rxs ^ even_parity(shift_r);
            end
`endif
            if (stop_c) begin
                stop_bad  <= ~rxs;
                load_pend <= 1'b1;
            end else if (load_c) begin
                load_pend <= 1'b0;
            end
            // A low stop bit blocks new frames until the line is seen high.
            if (load_c && stop_bad) begin
                wait_high <= 1'b1;
            end else if (rxs) begin
                wait_high <= 1'b0;
            end
        end
    end

    // Consumer-facing outputs: load wins over ack, overrun is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_c) begin
                data      <= shift_r;
                frame_err <= stop_bad;
`ifdef READ_UART_PARITY_EN
                parity_err <= par_bad;
`else
                parity_err <= 1'b0;
`endif
                valid     <= 1'b1;
                if (valid && !ack) begin
                    overrun <= 1'b1;
                end
            end else if (valid && ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_read_uart.sv
// Self-checking bench for read_uart: randomised frames against a behavioural
// model of the serial framing. Honours READ_UART_PARITY_EN like the RTL.
module tb_read_uart;

    localparam int unsigned FREQ    = 347;
    localparam int          BIT_CYC = FREQ + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor record of every valid-high cycle.
    int         vrises  = 0;
    int         vcycles = 0;
    logic [7:0] mon_data = 8'h00;
    logic       mon_pe   = 1'b0;
    logic       mon_fe   = 1'b0;
    logic       valid_q  = 1'b0;

    always #5 clk = ~clk;

    read_uart #(.freq(FREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .data       (data),
        .valid      (valid),
        .ack        (ack),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    // Sample outputs just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            vcycles++;
            if (!valid_q) vrises++;
            mon_data = data;
            mon_pe   = parity_err;
            mon_fe   = frame_err;
        end
        valid_q = (valid === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // One serial frame; flip corrupts the parity bit when parity is present.
    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        logic pbit;
        pbit = (^b) ^ flip;
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef READ_UART_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop);
    endtask

    // Reference parity flag for a frame sent with the given corruption.
    function automatic logic exp_pe(input logic flip);
`ifdef READ_UART_PARITY_EN
        return flip;
`else
        return 1'b0 & flip;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; RxD = 1'b1; ack = 1'b0;
        idle(4);
        n_checks++;
        if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
        n_checks++;
        if ({valid, parity_err, frame_err, overrun} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {valid, parity_err, frame_err, overrun});
        end
        rst = 1'b0;
        idle(BIT_CYC);
    endtask

    task automatic test_single();
        int r0, c0;
        r0 = vrises; c0 = vcycles;
        ack = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        n_checks++;
        if (vrises - r0 !== 1) begin n_fail++; $display("FAIL single_loads: got %0d want 1", vrises - r0); end
        n_checks++;
        if (vcycles - c0 !== 1) begin n_fail++; $display("FAIL single_pulse_len: got %0d want 1", vcycles - c0); end
        n_checks++;
        if (mon_data !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h want 55", mon_data); end
        n_checks++;
        if ({mon_pe, mon_fe} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got %b want 00", {mon_pe, mon_fe}); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_clear: got %b want 0", valid); end
    endtask

    task automatic test_parity();
        int r0;
        r0 = vrises;
        send_frame(8'hA7, 1'b1, 1'b1);
        idle(10);
        n_checks++;
        if (vrises - r0 !== 1) begin n_fail++; $display("FAIL parity_loads: got %0d want 1", vrises - r0); end
        n_checks++;
        if (mon_data !== 8'hA7) begin n_fail++; $display("FAIL parity_data: got %h want a7", mon_data); end
        n_checks++;
        if (mon_pe !== exp_pe(1'b1)) begin n_fail++; $display("FAIL parity_err_set: got %b want %b", mon_pe, exp_pe(1'b1)); end
        n_checks++;
        if (mon_fe !== 1'b0) begin n_fail++; $display("FAIL parity_fe: got %b want 0", mon_fe); end
        send_frame(8'h3A, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (mon_data !== 8'h3A || mon_pe !== 1'b0) begin
            n_fail++; $display("FAIL parity_clear: got %h/%b want 3a/0", mon_data, mon_pe);
        end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = vrises;
        @(negedge clk);
        RxD = 1'b0;
        idle(100);
        RxD = 1'b1;
        idle(2 * BIT_CYC);
        n_checks++;
        if (vrises !== r0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL glitch_no_frame: got loads %0d valid %b want 0 0", vrises - r0, valid);
        end
        send_frame(8'h96, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (vrises - r0 !== 1 || mon_data !== 8'h96) begin
            n_fail++; $display("FAIL glitch_recover: got loads %0d data %h want 1 96", vrises - r0, mon_data);
        end
    endtask

    task automatic test_frame_err();
        int r0;
        logic [7:0] b, c;
        b = 8'($urandom);
        c = 8'($urandom);
        r0 = vrises;
        send_frame(b, 1'b0, 1'b0);
        idle(2000);
        n_checks++;
        if (vrises - r0 !== 1) begin n_fail++; $display("FAIL ferr_loads: got %0d want 1", vrises - r0); end
        n_checks++;
        if (mon_fe !== 1'b1 || mon_data !== b) begin
            n_fail++; $display("FAIL ferr_flag: got fe %b data %h want 1 %h", mon_fe, mon_data, b);
        end
        RxD = 1'b1;
        idle(2 * BIT_CYC);
        n_checks++;
        if (vrises - r0 !== 1) begin n_fail++; $display("FAIL ferr_quiet: got %0d want 1", vrises - r0); end
        send_frame(c, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (vrises - r0 !== 2 || mon_data !== c || mon_fe !== 1'b0) begin
            n_fail++; $display("FAIL ferr_recover: got loads %0d data %h fe %b want 2 %h 0", vrises - r0, mon_data, mon_fe, c);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            int r0;
            logic [7:0] b;
            logic flip;
            b    = 8'($urandom);
            flip = 1'($urandom_range(0, 1));
            r0   = vrises;
            send_frame(b, flip, 1'b1);
            idle(int'($urandom_range(2, 40)));
            n_checks++;
            if (vrises - r0 !== 1 || mon_data !== b || mon_pe !== exp_pe(flip) || mon_fe !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d: got loads %0d data %h pe %b fe %b want 1 %h %b 0",
                         k, vrises - r0, mon_data, mon_pe, mon_fe, b, exp_pe(flip));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [2];
        int r0;
        b[0] = 8'($urandom);
        b[1] = 8'($urandom);
        r0 = vrises;
        for (int k = 0; k < 2; k++) begin
            send_frame(b[k], 1'b0, 1'b1);
            n_checks++;
            if (vrises - r0 !== k + 1 || mon_data !== b[k]) begin
                n_fail++; $display("FAIL b2b_%0d: got loads %0d data %h want %0d %h", k, vrises - r0, mon_data, k + 1, b[k]);
            end
        end
        idle(10);
    endtask

    task automatic test_overrun();
        ack = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        idle(5);
        n_checks++;
        if (data !== 8'h11 || valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_first: got %h %b %b want 11 1 0", data, valid, overrun);
        end
        send_frame(8'h22, 1'b0, 1'b1);
        idle(20);
        n_checks++;
        if (data !== 8'h22 || valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_second: got %h %b %b want 22 1 1", data, valid, overrun);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        idle(2);
        n_checks++;
        if (valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_ack: got valid %b overrun %b want 0 1", valid, overrun);
        end
    endtask

    task automatic test_rst_mid();
        int r0;
        ack = 1'b1;
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        RxD = 1'b0;
        idle(BIT_CYC / 2);
        rst = 1'b1;
        idle(3);
        n_checks++;
        if ({data, valid, parity_err, frame_err, overrun} !== 12'h000) begin
            n_fail++; $display("FAIL rst_mid_clear: got %h %b%b%b%b want 00 0000", data, valid, parity_err, frame_err, overrun);
        end
        RxD = 1'b1;
        idle(3);
        rst = 1'b0;
        r0 = vrises;
        idle(2 * BIT_CYC);
        n_checks++;
        if (vrises !== r0) begin n_fail++; $display("FAIL rst_mid_spurious: got %0d want 0", vrises - r0); end
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (vrises - r0 !== 1 || mon_data !== 8'h3C || {mon_pe, mon_fe} !== 2'b00 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_frame: got loads %0d data %h pe %b fe %b ovr %b want 1 3c 0 0 0",
                               vrises - r0, mon_data, mon_pe, mon_fe, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_glitch();
        test_frame_err();
        test_random();
        test_back_to_back();
        test_overrun();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
